// File: rtl/dm_pkg.sv
// Shared constants for the memory-access stage: datamem geometry, CPU word width
// and the state encoding of the access-control FSM.
package dm_pkg;

  localparam int DM_ADDR_W = 14;
  localparam int DM_DATA_W = 32;
  localparam int CPU_EA_W  = 19;

  typedef logic [1:0] dm_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Request/response channel between execute/writeback and the memory-access stage.
interface dm_access_ctrl_if
  import dm_pkg::*;
#(
  parameter int EA_W   = CPU_EA_W,
  parameter int DATA_W = DM_DATA_W
) ();

  // Both channels are plain valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the sender holds its payload stable while valid
  // is high and ready is low, and valid never waits on ready.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [EA_W-1:0]   req_base;
  logic [EA_W-1:0]   req_off;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_base, req_off, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_base, req_off, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dm_ea_check.sv
// Effective-address adder with datamem range check; the sum wraps at the CPU word width.
module dm_ea_check
  import dm_pkg::*;
#(
  parameter int EA_W   = CPU_EA_W,
  parameter int ADDR_W = DM_ADDR_W
) (
  input  logic [EA_W-1:0]   base,
  input  logic [EA_W-1:0]   off,
  output logic [ADDR_W-1:0] ea,
  output logic              oor
);

  logic [EA_W-1:0] sum;

  assign sum = base + off;
  assign ea  = sum[ADDR_W-1:0];
  // Any set bit above the datamem address field lands outside the 16K-word array.
  assign oor = |sum[EA_W-1:ADDR_W];

endmodule

// File: rtl/dm_access_ctrl.sv
// Memory-access stage: takes one load/store at a time, drives datamem for one
// cycle, waits out the read latency and hands the result to writeback.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int EA_W     = CPU_EA_W,
  parameter int ADDR_W   = DM_ADDR_W,
  parameter int DATA_W   = DM_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  dm_access_ctrl_if.slave   bus,
  output logic              we_DM,
  output logic [ADDR_W-1:0] addDM,
  output logic [DATA_W-1:0] dataDM,
  input  logic [DATA_W-1:0] outDM,
  output dm_state_t         state
);

  localparam int              CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

  dm_state_t         state_q;
  logic              is_store;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic [ADDR_W-1:0] ea;
  logic              oor;

  dm_ea_check #(
    .EA_W   (EA_W),
    .ADDR_W (ADDR_W)
  ) u_ea_check (
    .base (bus.req_base),
    .off  (bus.req_off),
    .ea   (ea),
    .oor  (oor)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      is_store <= 1'b0;
      cnt      <= '0;
      we_DM    <= 1'b0;
      addDM    <= '0;
      dataDM   <= '0;
      rdata    <= '0;
      err      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            is_store <= bus.req_we;
            rdata    <= '0;
            if (oor) begin
              // datamem is left alone: address/data keep their last values.
              err     <= 1'b1;
              state_q <= ST_RESP;
            end else begin
              err     <= 1'b0;
              addDM   <= ea;
              dataDM  <= bus.req_wdata;
              we_DM   <= bus.req_we;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          we_DM <= 1'b0;
          if (is_store) begin
            state_q <= ST_RESP;
          end else begin
            cnt     <= CNT_INIT;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            rdata   <= outDM;
            state_q <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Ready and valid are pure state decodes, so they are glitch-free and reset-correct.
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = err;
  assign state         = state_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed and randomised bench for dm_access_ctrl with a behavioural datamem
// (READ_LAT=1) and a response scoreboard.
module tb_dm_access_ctrl;
  import dm_pkg::*;

  localparam int EA_W     = CPU_EA_W;
  localparam int ADDR_W   = DM_ADDR_W;
  localparam int DATA_W   = DM_DATA_W;
  localparam int READ_LAT = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT and datamem ----------------
  dm_access_ctrl_if #(.EA_W(EA_W), .DATA_W(DATA_W)) bus ();

  logic              we_DM;
  logic [ADDR_W-1:0] addDM;
  logic [DATA_W-1:0] dataDM;
  logic [DATA_W-1:0] outDM;
  dm_state_t         state;

  dm_access_ctrl #(
    .EA_W(EA_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .we_DM(we_DM), .addDM(addDM), .dataDM(dataDM), .outDM(outDM), .state(state)
  );

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (we_DM) mem[addDM] <= dataDM;
    outDM <= mem[addDM];
  end

  // Standalone instance of the EA checker for its own unit vectors.
  logic [EA_W-1:0]   u_base, u_off;
  logic [ADDR_W-1:0] u_ea;
  logic              u_oor;
  dm_ea_check #(.EA_W(EA_W), .ADDR_W(ADDR_W)) u_ea_chk (
    .base(u_base), .off(u_off), .ea(u_ea), .oor(u_oor)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0]       acc;
    logic [3:0]        lat;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int rsp_cnt = 0;
  int last_acc = 0;
  logic [ADDR_W-1:0] we_addr = '0;
  logic in_rsp = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (we_DM) begin
      we_cnt++;
      we_addr = addDM;
    end
    if (!rst && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp", 64'(bus.rsp_valid), 64'd0);
      end else begin
        if (!in_rsp) begin
          check("rsp_latency", 64'(cyc - int'(exp_q[0].acc)), 64'(exp_q[0].lat));
          in_rsp = 1'b1;
        end
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_q[0].rdata));
        check("rsp_err", 64'(bus.rsp_err), 64'(exp_q[0].err));
        if (bus.rsp_ready) begin
          void'(exp_q.pop_front());
          in_rsp = 1'b0;
          rsp_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [EA_W-1:0] base, input logic [EA_W-1:0] off,
                      input logic [DATA_W-1:0] wdata, input logic exp_err,
                      input logic [DATA_W-1:0] exp_rdata, input logic keep);
    int t;
    exp_t e;
    t = 0;
    bus.req_we    = we;
    bus.req_base  = base;
    bus.req_off   = off;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && t < 50) begin
      tick();
      t++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 64'(bus.req_ready), 64'd1);
    end else begin
      last_acc = cyc;
      e.acc   = 32'(cyc);
      e.lat   = exp_err ? 4'd1 : (we ? 4'd2 : 4'(2 + READ_LAT));
      e.err   = exp_err;
      e.rdata = exp_rdata;
      exp_q.push_back(e);
    end
    tick();
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && t < 100) begin
      tick();
      t++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic ea_vec(input logic [EA_W-1:0] b, input logic [EA_W-1:0] o,
                        input logic [ADDR_W-1:0] exp_ea, input logic exp_oor);
    u_base = b;
    u_off  = o;
    #1;
    check("ea_unit_ea", 64'(u_ea), 64'(exp_ea));
    check("ea_unit_oor", 64'(u_oor), 64'(exp_oor));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 64'(we_DM), 64'd0);
    check({tag, "_addr"}, 64'(addDM), 64'd0);
    check({tag, "_data"}, 64'(dataDM), 64'd0);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    check({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w0, a1;
    logic [ADDR_W-1:0] a0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_base  = '0;
    bus.req_off   = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    // EA checker unit vectors, including wrap and the top of the array.
    ea_vec(19'h00010, 19'h00005, 14'h0015, 1'b0);
    ea_vec(19'h04000, 19'h00000, 14'h0000, 1'b1);
    ea_vec(19'h00003, 19'h7FFFF, 14'h0002, 1'b0);
    ea_vec(19'h00000, 19'h7FFFF, 14'h3FFF, 1'b1);
    ea_vec(19'h03FFF, 19'h00000, 14'h3FFF, 1'b0);
    ea_vec(19'h7FFFF, 19'h04001, 14'h0000, 1'b1);

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("reset");

    // 1: store then load the same EA
    w0 = we_cnt;
    send(1'b1, 19'h00010, 19'h00005, 32'h1DFE, 1'b0, 32'h0, 1'b0);
    check("t1_issue_we", 64'(we_DM), 64'd1);
    check("t1_issue_addr", 64'(addDM), 64'h15);
    drain();
    check("t1_we_pulses", 64'(we_cnt - w0), 64'd1);
    check("t1_we_addr", 64'(we_addr), 64'h15);
    send(1'b0, 19'h00010, 19'h00005, 32'h0, 1'b0, 32'h00001DFE, 1'b0);
    drain();
    check("t1_load_no_we", 64'(we_cnt - w0), 64'd1);

    // 2: out-of-range load leaves datamem untouched
    a0 = addDM;
    w0 = we_cnt;
    send(1'b0, 19'h04000, 19'h00000, 32'h0, 1'b1, 32'h0, 1'b0);
    drain();
    check("t2_addr_kept", 64'(addDM), 64'(a0));
    check("t2_no_we", 64'(we_cnt - w0), 64'd0);

    // 3: negative offset, and wrap to an out-of-range EA
    send(1'b1, 19'h00002, 19'h00000, 32'hABCD0002, 1'b0, 32'h0, 1'b0);
    drain();
    send(1'b0, 19'h00003, 19'h7FFFF, 32'h0, 1'b0, 32'hABCD0002, 1'b0);
    check("t3_neg_off_addr", 64'(addDM), 64'h2);
    drain();
    a0 = addDM;
    send(1'b0, 19'h00000, 19'h7FFFF, 32'h0, 1'b1, 32'h0, 1'b0);
    drain();
    check("t3_oor_addr_kept", 64'(addDM), 64'(a0));

    // 4: top address plus writeback back-pressure
    send(1'b1, 19'h03FFF, 19'h00000, 32'h1001, 1'b0, 32'h0, 1'b0);
    check("t4_top_addr", 64'(addDM), 64'h3FFF);
    drain();
    bus.rsp_ready = 1'b0;
    w0 = we_cnt;
    send(1'b0, 19'h03FFF, 19'h00000, 32'h0, 1'b0, 32'h00001001, 1'b0);
    begin
      int t;
      t = 0;
      while (!bus.rsp_valid && t < 10) begin
        tick();
        t++;
      end
      check("t4_rsp_seen", 64'(bus.rsp_valid), 64'd1);
    end
    repeat (5) begin
      tick();
      check("t4_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("t4_hold_req_ready", 64'(bus.req_ready), 64'd0);
      check("t4_hold_addr", 64'(addDM), 64'h3FFF);
    end
    check("t4_no_extra_we", 64'(we_cnt - w0), 64'd0);
    bus.rsp_ready = 1'b1;
    drain();

    // 5: reset while a load waits on datamem; its response must never appear
    send(1'b0, 19'h00100, 19'h00000, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    check("t5_in_wait", 64'(state), 64'(ST_WAIT));
    void'(exp_q.pop_back());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("t5_reset");
    repeat (6) tick();

    // 6: back-to-back requests with req_valid held high
    send(1'b1, 19'h00200, 19'h00000, 32'h000000A1, 1'b0, 32'h0, 1'b1);
    a1 = last_acc;
    send(1'b0, 19'h00200, 19'h00000, 32'h0, 1'b0, 32'h000000A1, 1'b1);
    check("t6_gap_store", 64'(last_acc - a1), 64'd3);
    a1 = last_acc;
    send(1'b1, 19'h00201, 19'h00000, 32'h000000B2, 1'b0, 32'h0, 1'b1);
    check("t6_gap_load", 64'(last_acc - a1), 64'd4);
    a1 = last_acc;
    send(1'b0, 19'h00201, 19'h00000, 32'h0, 1'b0, 32'h000000B2, 1'b0);
    check("t6_gap_store2", 64'(last_acc - a1), 64'd3);
    drain();

    // Random in-range store/load pairs with the EA split between base and offset.
    repeat (6) begin
      int a, b;
      logic [DATA_W-1:0] d;
      a = $urandom_range(0, (1 << ADDR_W) - 1);
      b = $urandom_range(0, a);
      d = $urandom;
      send(1'b1, EA_W'(b), EA_W'(a - b), d, 1'b0, 32'h0, 1'b0);
      drain();
      send(1'b0, EA_W'(b), EA_W'(a - b), 32'h0, 1'b0, d, 1'b0);
      drain();
    end

    check("rsp_total", 64'(rsp_cnt), 64'd24);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
